wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: entries in the long-latency result buffer; legal values 2..8.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive lost arbitration cycles before a bubble is requested.
REQ-003 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_pipe_write  in  1  pipeline writeback request; it cannot be back-pressured.
REQ-006 i_pipe_data  in  32  pipeline write data.
REQ-007 i_pipe_rd  in  6  pipeline destination register.
REQ-008 i_lu_valid  in  1  long-latency unit (mul/div) result valid.
REQ-009 o_lu_ready  out  1  arbiter can accept a long-latency result.
REQ-010 i_lu_data  in  32  long-latency result data.
REQ-011 i_lu_rd  in  6  long-latency destination register.
REQ-012 o_write  out  1  regfile write enable (registered).
REQ-013 o_data  out  32  regfile write data (registered).
REQ-014 o_regno  out  6  regfile write register (registered).
REQ-015 o_pipe_stall  out  1  bubble request to the pipeline (registered).
REQ-016 o_proto_err  out  1  sticky protocol-violation flag.

Function
REQ-017 Long-latency handshake: transfer occurs when i_lu_valid && o_lu_ready; o_lu_ready = (count != DEPTH), from registered state only.
REQ-018 Per-cycle source priority: (1) i_pipe_write; (2) FIFO head if count>0; (3) same-cycle LU transfer bypassed directly when count==0; (4) none.
REQ-019 Winner's data/rd appear on o_data/o_regno, with o_write=1, at the next rising edge; latency is exactly 1 cycle for all sources.
REQ-020 No winner: o_write=0 next cycle; o_data/o_regno hold their previous values.
REQ-021 A winner with rd==0 produces o_write=0 but is consumed (FIFO popped, bypass consumed).
REQ-022 A LU transfer not bypassed is pushed at the FIFO tail; push and pop in the same cycle leave count unchanged.
REQ-023 Pointers wrap modulo DEPTH; count range is 0..DEPTH; overflow and underflow are impossible by construction.
REQ-024 FIFO output order equals LU acceptance order; no entry is ever dropped or duplicated.
REQ-025 Starve counter increments each cycle count>0 and the pipeline wins; it clears on any FIFO pop or when count==0; it saturates at STARVE_LIMIT.
REQ-026 When the starve counter reaches STARVE_LIMIT, o_pipe_stall=1 for exactly one cycle, and the counter clears.
REQ-027 Contract: in the cycle after o_pipe_stall=1, the pipeline presents i_pipe_write=0, so the FIFO head wins.
REQ-028 Contract violation (i_pipe_write=1 the cycle after o_pipe_stall=1): the pipeline still wins, o_proto_err sets and stays 1 until reset.
REQ-029 Register ordering between the two sources (same rd) is the issue stage's responsibility; the arbiter does not reorder or merge.

Reset
REQ-030 While i_rst_n=0: o_write=0, o_data=0, o_regno=0, o_pipe_stall=0, o_proto_err=0, count=0, pointers=0, starve counter=0, o_lu_ready=1.
REQ-031 Reset asserted mid-operation discards all buffered entries immediately; the first write after deassertion comes only from new requests.

Verification
REQ-032 Pipe only: i_pipe_write=1, rd=5, data=0xDEADBEEF -> next cycle o_write=1, o_regno=5, o_data=0xDEADBEEF.
REQ-033 Bypass: idle pipe, empty FIFO, LU rd=7, data=0x12345678 -> next cycle o_write=1, o_regno=7; count stays 0.
REQ-034 Collision: pipe rd=3 and LU rd=9 in the same cycle -> cycle+1 writes r3, cycle+2 writes r9 (pipe idle).
REQ-035 Full: pipe busy, LU pushes 2 results -> o_lu_ready=0 at count=2; then pipe idle -> r-order preserved, ready returns 1 after first pop.
REQ-036 Starvation (DEPTH=2, LIMIT=4): FIFO nonempty, pipe writes every cycle -> o_pipe_stall pulses after 4 cycles; pipe idles -> head written; if pipe writes instead, o_proto_err=1.
REQ-037 Reset: assert i_rst_n=0 with count=2 -> all outputs 0, o_lu_ready=1; no buffered entry appears after release.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the pipeline/long-latency unit and the regfile arbiter.
// The slave modport is the arbiter's view; master is the requesters/regfile view.
interface wb_arbiter_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 6;

    logic              i_pipe_write;
    logic [DATA_W-1:0] i_pipe_data;
    logic [RD_W-1:0]   i_pipe_rd;
    logic              i_lu_valid;
    logic              o_lu_ready;
    logic [DATA_W-1:0] i_lu_data;
    logic [RD_W-1:0]   i_lu_rd;
    logic              o_write;
    logic [DATA_W-1:0] o_data;
    logic [RD_W-1:0]   o_regno;
    logic              o_pipe_stall;
    logic              o_proto_err;

    modport slave (
        input  i_pipe_write, i_pipe_data, i_pipe_rd,
        input  i_lu_valid, i_lu_data, i_lu_rd,
        output o_lu_ready,
        output o_write, o_data, o_regno, o_pipe_stall, o_proto_err
    );

    modport master (
        output i_pipe_write, i_pipe_data, i_pipe_rd,
        output i_lu_valid, i_lu_data, i_lu_rd,
        input  o_lu_ready,
        input  o_write, o_data, o_regno, o_pipe_stall, o_proto_err
    );
endinterface

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter: pipeline writebacks have priority, long-latency
// results are buffered in a small FIFO and a stall bubble is requested on starvation.
module wb_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    wb_arbiter_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 6;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned STV_W  = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t              mem_q [DEPTH];
    entry_t              mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [STV_W-1:0]    starve_q, starve_d;
    logic                stall_q, stall_d;
    logic                err_q, err_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [RD_W-1:0]     regno_q, regno_d;

    logic                lu_ready_c;
    logic                lu_xfer;
    logic                empty;
    logic                win;
    logic                push;
    logic                pop;
    entry_t              win_e;
    entry_t              lu_e;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // State registers; reset discards any buffered results.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            data_q   <= '0;
            regno_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
            write_q  <= write_d;
            data_q   <= data_d;
            regno_q  <= regno_d;
        end
    end

    // Arbitration, FIFO bookkeeping and starvation tracking.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        stall_d  = 1'b0;
        err_d    = err_q;
        write_d  = 1'b0;
        data_d   = data_q;
        regno_d  = regno_q;
        win      = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;

        lu_ready_c = (count_q != CNT_W'(DEPTH));
        lu_xfer    = bus.i_lu_valid && lu_ready_c;
        empty      = (count_q == '0);
        lu_e       = '{rd: bus.i_lu_rd, data: bus.i_lu_data};
        win_e      = mem_q[rd_ptr_q];

        if (bus.i_pipe_write) begin
            win   = 1'b1;
            win_e = '{rd: bus.i_pipe_rd, data: bus.i_pipe_data};
            push  = lu_xfer;
        end else if (!empty) begin
            win  = 1'b1;
            pop  = 1'b1;
            push = lu_xfer;
        end else if (lu_xfer) begin
            win   = 1'b1;
            win_e = lu_e;
        end

        // r0 writes are consumed but never reach the regfile.
        if (win) begin
            write_d = (win_e.rd != '0);
            data_d  = win_e.data;
            regno_d = win_e.rd;
        end

        if (push) begin
            mem_d[wr_ptr_q] = lu_e;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pop || empty) begin
            starve_d = '0;
        end else if (bus.i_pipe_write) begin
            if (starve_q >= STV_W'(STARVE_LIMIT - 1)) begin
                starve_d = '0;
                stall_d  = 1'b1;
            end else begin
                starve_d = starve_q + STV_W'(1);
            end
        end

        if (stall_q && bus.i_pipe_write) err_d = 1'b1;
    end

    assign bus.o_lu_ready   = lu_ready_c;
    assign bus.o_write      = write_q;
    assign bus.o_data       = data_q;
    assign bus.o_regno      = regno_q;
    assign bus.o_pipe_stall = stall_q;
    assign bus.o_proto_err  = err_q;
endmodule
